// File: rtl/uart_pkg.sv
// Shared UART framing constants and a byte-lane helper for the receive and transmit paths.
package uart_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

    // Little-endian lane index: lane 0 occupies bits [BYTE_W-1:0].
    function automatic logic [WORD_W-1:0] put_byte(
        input logic [WORD_W-1:0] word,
        input logic [IDX_W-1:0]  lane,
        input logic [BYTE_W-1:0] data
    );
        logic [WORD_W-1:0] result;
        result = word;
        result[lane*BYTE_W +: BYTE_W] = data;
        return result;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with registered pointers and a clear input.
// The caller qualifies push/pop: push only when a slot is free (or freed by a same-cycle pop), pop only when non-empty.
module sync_fifo_fwft #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL  = DEPTH;

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; its contents only matter behind valid pointers.
    always_ff @(posedge clk) begin
        if (rstn && !clr && push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = (r_count == CNT_FULL);
    assign empty = (r_count == '0);

endmodule

// File: rtl/uart_rx_wordbuf.sv
// Packs the UART receiver byte stream into little-endian 32-bit words and queues them for the core,
// with sticky overflow and framing-error flags.
module uart_rx_wordbuf
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [BYTE_W-1:0]     rx_data,
    input  logic                  rx_pulse,
    input  logic                  rx_ferr,
    input  logic                  flush,
    input  logic                  clear_err,
    output logic [WORD_W-1:0]     word,
    output logic                  word_valid,
    input  logic                  word_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic [IDX_W-1:0]      byte_idx,
    output logic                  overflow,
    output logic                  frame_err
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = 1;

    logic [IDX_W-1:0]  r_byte_idx;
    logic [WORD_W-1:0] r_partial;
    logic              r_overflow;
    logic              r_frame_err;

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push_req;
    logic              w_push_ok;
    logic              w_drop;
    logic [WORD_W-1:0] w_din;

    // Flush outranks everything: a same-cycle byte or pop is simply discarded.
    assign w_pop      = ~w_empty & word_ready & ~flush;
    assign w_push_req = rx_pulse & (r_byte_idx == IDX_LAST) & ~flush;
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_drop     = w_push_req & ~w_push_ok;

    // The completing byte goes straight into the top lane rather than via r_partial.
    assign w_din = {rx_data, r_partial[WORD_W-BYTE_W-1:0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_byte_idx <= '0;
            r_partial  <= '0;
        end else if (flush) begin
            r_byte_idx <= '0;
        end else if (rx_pulse) begin
            r_partial  <= put_byte(r_partial, r_byte_idx, rx_data);
            r_byte_idx <= r_byte_idx + IDX_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~clear_err) | w_drop;
            r_frame_err <= (r_frame_err & ~clear_err) | rx_ferr;
        end
    end

    sync_fifo_fwft #(
        .WIDTH      (WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (flush),
        .push  (w_push_ok),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (word),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign word_valid = ~w_empty;
    assign byte_idx   = r_byte_idx;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_rx_wordbuf.sv
// Scoreboard bench for uart_rx_wordbuf: stimulus queues expected words, a negedge monitor checks each pop.
module tb_uart_rx_wordbuf;

    localparam int DEPTH_LOG2 = 4;

    logic                clk = 1'b0;
    logic                rstn;
    logic [7:0]          rx_data;
    logic                rx_pulse;
    logic                rx_ferr;
    logic                flush;
    logic                clear_err;
    logic [31:0]         word;
    logic                word_valid;
    logic                word_ready;
    logic [DEPTH_LOG2:0] count;
    logic [1:0]          byte_idx;
    logic                overflow;
    logic                frame_err;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];

    uart_rx_wordbuf #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rx_data    (rx_data),
        .rx_pulse   (rx_pulse),
        .rx_ferr    (rx_ferr),
        .flush      (flush),
        .clear_err  (clear_err),
        .word       (word),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .count      (count),
        .byte_idx   (byte_idx),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: inputs are stable between edges, so at negedge valid&ready means a pop at the next posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn === 1'b1 && word_valid === 1'b1 && word_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got 0x%08h expected no word", word);
                end else begin
                    check("pop_word", word, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic rdy, input int gap);
        rx_data    = b;
        rx_pulse   = 1'b1;
        word_ready = rdy;
        tick(1);
        rx_pulse   = 1'b0;
        word_ready = 1'b0;
        if (gap > 0) tick(gap);
    endtask

    // Sends w least-significant byte first; keep says whether the word should survive in the FIFO.
    task automatic send_word(input logic [31:0] w, input logic keep, input logic rdy_last);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[i*8 +: 8], (i == 3) ? rdy_last : 1'b0, (i == 3) ? 0 : 1);
            if (i == 3 && keep) exp_q.push_back(w);
        end
    endtask

    task automatic drain(input int n);
        word_ready = 1'b1;
        tick(n);
        word_ready = 1'b0;
    endtask

    function automatic logic [31:0] fill_word(input int i);
        return {8'hC0, 8'h22, 8'h11, 8'(i)};
    endfunction

    initial begin
        rstn = 1'b0; rx_data = '0; rx_pulse = 1'b0; rx_ferr = 1'b0;
        flush = 1'b0; clear_err = 1'b0; word_ready = 1'b0;
        tick(2);
        check("rst_valid", {31'd0, word_valid}, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_idx",   32'(byte_idx), 32'd0);
        check("rst_ovf",   {31'd0, overflow}, 32'd0);
        check("rst_ferr",  {31'd0, frame_err}, 32'd0);
        rstn = 1'b1;
        tick(1);

        // Basic little-endian assembly, pulses 5 cycles apart.
        send_byte(8'h78, 1'b0, 4);
        send_byte(8'h56, 1'b0, 4);
        send_byte(8'h34, 1'b0, 4);
        check("t1_idx3",   32'(byte_idx), 32'd3);
        check("t1_novalid", {31'd0, word_valid}, 32'd0);
        send_byte(8'h12, 1'b0, 0);
        exp_q.push_back(32'h12345678);
        check("t1_valid", {31'd0, word_valid}, 32'd1);
        check("t1_word",  word, 32'h12345678);
        check("t1_count", 32'(count), 32'd1);
        check("t1_idx",   32'(byte_idx), 32'd0);
        drain(1);
        check("t1_empty", {31'd0, word_valid}, 32'd0);

        // Fill to 16 with no consumer, then a 17th word is dropped.
        for (int i = 1; i <= 16; i++) send_word(fill_word(i), 1'b1, 1'b0);
        check("t2_count16", 32'(count), 32'd16);
        check("t2_noovf",   {31'd0, overflow}, 32'd0);
        send_word(fill_word(17), 1'b0, 1'b0);
        check("t2_ovf",     {31'd0, overflow}, 32'd1);
        check("t2_count",   32'(count), 32'd16);
        check("t2_idx",     32'(byte_idx), 32'd0);
        drain(16);
        check("t2_drained", 32'(count), 32'd0);
        check("t2_sb",      32'(exp_q.size()), 32'd0);

        // Full FIFO with a coincident pop: the new word is accepted and lands last.
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("t3_ovfclr", {31'd0, overflow}, 32'd0);
        for (int i = 1; i <= 16; i++) send_word(fill_word(i + 32), 1'b1, 1'b0);
        send_word(32'hA5A5_5A5A, 1'b1, 1'b1);
        check("t3_noovf", {31'd0, overflow}, 32'd0);
        check("t3_count", 32'(count), 32'd16);
        drain(16);
        check("t3_sb",    32'(exp_q.size()), 32'd0);
        check("t3_empty", {31'd0, word_valid}, 32'd0);

        // Flush discards a partial word.
        send_byte(8'h01, 1'b0, 1);
        send_byte(8'h02, 1'b0, 1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t4_idx_flush", 32'(byte_idx), 32'd0);
        send_word(32'hDEADBEEF, 1'b1, 1'b0);
        check("t4_idx",   32'(byte_idx), 32'd0);
        check("t4_count", 32'(count), 32'd1);
        check("t4_word",  word, 32'hDEADBEEF);
        drain(1);

        // Framing error stickiness and clear behaviour.
        rx_ferr = 1'b1;
        tick(1);
        rx_ferr = 1'b0;
        tick(2);
        check("t5_ferr_held", {31'd0, frame_err}, 32'd1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check("t5_ferr_clr", {31'd0, frame_err}, 32'd0);
        rx_ferr = 1'b1;
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        tick(1);
        rx_ferr = 1'b0;
        tick(1);
        check("t5_ferr_kept", {31'd0, frame_err}, 32'd1);

        // Reset mid-word with two queued words.
        send_word(32'h0BAD_F00D, 1'b1, 1'b0);
        send_word(32'h1357_9BDF, 1'b1, 1'b0);
        send_byte(8'h11, 1'b0, 1);
        send_byte(8'h22, 1'b0, 1);
        send_byte(8'h33, 1'b0, 1);
        check("t6_pre_count", 32'(count), 32'd2);
        rstn = 1'b0;
        tick(1);
        exp_q.delete();
        check("t6_count", 32'(count), 32'd0);
        check("t6_valid", {31'd0, word_valid}, 32'd0);
        check("t6_idx",   32'(byte_idx), 32'd0);
        check("t6_ovf",   {31'd0, overflow}, 32'd0);
        check("t6_ferr",  {31'd0, frame_err}, 32'd0);
        rstn = 1'b1;
        tick(1);
        send_word(32'hCAFE_F00D, 1'b1, 1'b0);
        check("t6_fresh_count", 32'(count), 32'd1);
        check("t6_fresh_word",  word, 32'hCAFE_F00D);
        drain(1);
        tick(2);
        check("end_sb", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
